pattern_tx: RTL and testbench

Serial pattern transmitter: the drive end of the single-bit `seq_in` line that the 0001 sequence detector monitors. Accepts a parallel word over a valid/ready handshake and shifts it out MSB-first on a one-bit serial line. Each word is prefixed with a fixed sync preamble (default `0001`) and followed by an idle-high gap bit. The block feeds detector test harnesses and board-level stimulus, and is the source side of the string-recognition link.

---
 rtl/pattern_tx.sv | 171 +++++++++++++++++
 tb/tb_pattern_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_tx.sv
// pattern_tx: serial pattern source. Accepts a parallel word over valid/ready and
// sends it as PREAMBLE (MSB first), then the word (MSB first), then one idle-high gap bit.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | line high, ready for a word
// S_PRE  | sending preamble bits, bit counter walks PRE_LEN-1 .. 0
// S_DATA | sending word bits from the shift register MSB
// S_GAP  | one idle-high bit period closing the frame
module pattern_tx #(
  parameter int                 WIDTH    = 8,
  parameter int                 DIV      = 1,
  parameter int                 PRE_LEN  = 4,
  parameter logic [PRE_LEN-1:0] PREAMBLE = 4'b0001
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             seq_out,
  output logic             bit_strobe,
  output logic             busy,
  output logic             frame_done
);

  // The bit counter indexes both the preamble and the word, so size it for the longer.
  localparam int CNT_MAX = (PRE_LEN > WIDTH) ? PRE_LEN : WIDTH;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_LEN - 1);
  localparam logic [CW-1:0] WORD_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DW-1:0]    r_div;
  logic [DW-1:0]    w_div_nxt;
  logic [CW-1:0]    r_bitcnt;
  logic [CW-1:0]    w_bitcnt_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;

  logic r_seq_out;
  logic r_ready;
  logic r_busy;
  logic r_bit_strobe;
  logic r_frame_done;

  logic w_bit_end;
  logic w_pre_bit;
  logic w_seq_nxt;

  assign w_bit_end = (r_div == DIV_LAST);

  // Next-state logic: divider, bit counter, shift register and state transitions.
  always_comb begin
    w_state_nxt  = r_state;
    w_div_nxt    = r_div;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;

    if (r_state != S_IDLE) begin
      if (w_bit_end) begin
        w_div_nxt = '0;
      end else begin
        w_div_nxt = r_div + 1'b1;
      end
    end

    case (r_state)
      S_IDLE: begin
        // data_ready is always high here, so valid alone means accept.
        if (data_valid) begin
          w_state_nxt  = S_PRE;
          w_shift_nxt  = data_in;
          w_bitcnt_nxt = PRE_LAST;
          w_div_nxt    = '0;
        end
      end
      S_PRE: begin
        if (w_bit_end) begin
          if (r_bitcnt == '0) begin
            w_state_nxt  = S_DATA;
            w_bitcnt_nxt = WORD_LAST;
          end else begin
            w_bitcnt_nxt = r_bitcnt - 1'b1;
          end
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
          if (r_bitcnt == '0) begin
            w_state_nxt = S_GAP;
          end else begin
            w_bitcnt_nxt = r_bitcnt - 1'b1;
          end
        end
      end
      S_GAP: begin
        if (w_bit_end) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Preamble bit selected by the upcoming bit counter value.
  always_comb begin
    w_pre_bit = 1'b1;
    for (int i = 0; i < PRE_LEN; i++) begin
      if (w_bitcnt_nxt == CW'(i)) begin
        w_pre_bit = PREAMBLE[i];
      end
    end
  end

  // Line value for the upcoming cycle; registered below so seq_out has no input path.
  always_comb begin
    w_seq_nxt = 1'b1;
    case (w_state_nxt)
      S_PRE:   w_seq_nxt = w_pre_bit;
      S_DATA:  w_seq_nxt = w_shift_nxt[WIDTH-1];
      default: w_seq_nxt = 1'b1;
    endcase
  end

  // State and output registers; reset wins over a same-cycle accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_div        <= '0;
      r_bitcnt     <= '0;
      r_shift      <= '0;
      r_seq_out    <= 1'b1;
      r_ready      <= 1'b1;
      r_busy       <= 1'b0;
      r_bit_strobe <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_div        <= w_div_nxt;
      r_bitcnt     <= w_bitcnt_nxt;
      r_shift      <= w_shift_nxt;
      r_seq_out    <= w_seq_nxt;
      r_ready      <= (w_state_nxt == S_IDLE);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_bit_strobe <= (w_state_nxt != S_IDLE) && (w_div_nxt == '0);
      r_frame_done <= (w_state_nxt == S_GAP) && (w_div_nxt == DIV_LAST);
    end
  end

  assign data_ready = r_ready;
  assign seq_out    = r_seq_out;
  assign busy       = r_busy;
  assign bit_strobe = r_bit_strobe;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_pattern_tx.sv
// Bench for pattern_tx: two instances (DIV=1 and DIV=3) share one stimulus stream and
// are compared every cycle against a frame-level model, plus literal expectations.
module tb_pattern_tx;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic [1:0] rdy_o;
  logic [1:0] seq_o;
  logic [1:0] stb_o;
  logic [1:0] busy_o;
  logic [1:0] fd_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: position within the current frame (-1 = idle) and the 13 frame bits.
  int          m_t[2];
  logic [12:0] m_frame[2];

  always #5 clock = ~clock;

  pattern_tx #(.WIDTH(8), .DIV(1), .PRE_LEN(4), .PREAMBLE(4'b0001)) u_div1 (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy_o[0]), .seq_out(seq_o[0]), .bit_strobe(stb_o[0]),
    .busy(busy_o[0]), .frame_done(fd_o[0]));

  pattern_tx #(.WIDTH(8), .DIV(3), .PRE_LEN(4), .PREAMBLE(4'b0001)) u_div3 (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy_o[1]), .seq_out(seq_o[1]), .bit_strobe(stb_o[1]),
    .busy(busy_o[1]), .frame_done(fd_o[1]));

  function automatic int div_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic check_bit(input string name, input int d, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d @%0t got %b want %b", name, d, $time, act, exp);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t got 'h%0h want 'h%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy_o != 2'b00) && (n < budget)) begin
      tick();
      n++;
    end
    check_val("idle_timeout", int'(busy_o), 0);
  endtask

  // Frame model update: a frame is PREAMBLE, word MSB first, one high gap bit, DIV cycles each.
  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_t[d] = -1;
      end else if (m_t[d] < 0) begin
        if (data_valid) begin
          m_frame[d] = {4'b0001, data_in, 1'b1};
          m_t[d]     = 0;
        end
      end else begin
        m_t[d] = m_t[d] + 1;
        if (m_t[d] == 13 * div_of(d)) m_t[d] = -1;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        logic        e_seq, e_rdy, e_busy, e_stb, e_fd;
        logic [12:0] sh;
        if (m_t[d] < 0) begin
          e_seq = 1'b1; e_rdy = 1'b1; e_busy = 1'b0; e_stb = 1'b0; e_fd = 1'b0;
        end else begin
          sh     = m_frame[d] >> (12 - m_t[d] / div_of(d));
          e_seq  = sh[0];
          e_rdy  = 1'b0;
          e_busy = 1'b1;
          e_stb  = ((m_t[d] % div_of(d)) == 0);
          e_fd   = (m_t[d] == 13 * div_of(d) - 1);
        end
        check_bit("seq_out", d, seq_o[d], e_seq);
        check_bit("data_ready", d, rdy_o[d], e_rdy);
        check_bit("busy", d, busy_o[d], e_busy);
        check_bit("bit_strobe", d, stb_o[d], e_stb);
        check_bit("frame_done", d, fd_o[d], e_fd);
      end
    end
  end

  initial begin
    logic [13:0] g_seq, g_fd, g_rdy, g_stb;
    logic [3:0]  hist;
    int          nb, ns, nfd0, nfd1, nmatch;

    m_t[0] = -1;
    m_t[1] = -1;
    reset      = 1'b1;
    data_valid = 1'b0;
    data_in    = 8'h00;

    // Reset held for three cycles, then released with valid low.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_en = 1'b1;
      for (int d = 0; d < 2; d++) begin
        check_bit("rst_seq", d, seq_o[d], 1'b1);
        check_bit("rst_ready", d, rdy_o[d], 1'b1);
        check_bit("rst_busy", d, busy_o[d], 1'b0);
      end
    end
    reset = 1'b0;
    tick();
    tick();
    check_bit("idle_seq", 0, seq_o[0], 1'b1);

    // Single frame of 0xA5 on the DIV=1 instance.
    data_in = 8'hA5; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    for (int i = 0; i < 14; i++) begin
      g_seq = {g_seq[12:0], seq_o[0]};
      g_fd  = {g_fd[12:0], fd_o[0]};
      g_rdy = {g_rdy[12:0], rdy_o[0]};
      g_stb = {g_stb[12:0], stb_o[0]};
      tick();
    end
    check_val("a5_seq", int'(g_seq), int'(14'b00011010010111));
    check_val("a5_frame_done", int'(g_fd), int'(14'b00000000000010));
    check_val("a5_ready", int'(g_rdy), int'(14'b00000000000001));
    check_val("a5_strobe", int'(g_stb), int'(14'b11111111111110));
    wait_idle(100);

    // 0x80 on the DIV=3 instance: 13 bits of 3 cycles each.
    data_in = 8'h80; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    nb = 0; ns = 0;
    for (int i = 0; i < 50; i++) begin
      nb += int'(busy_o[1]);
      ns += int'(stb_o[1]);
      tick();
    end
    check_val("div3_busy_cycles", nb, 39);
    check_val("div3_strobes", ns, 13);
    wait_idle(100);

    // Valid held high with a changing word: only IDLE-cycle words are sent.
    data_valid = 1'b1;
    nfd0 = 0; nfd1 = 0;
    for (int i = 0; i < 56; i++) begin
      data_in = 8'($urandom);
      tick();
      nfd0 += int'(fd_o[0]);
      nfd1 += int'(fd_o[1]);
    end
    data_valid = 1'b0;
    check_val("b2b_frames_div1", nfd0, 4);
    check_val("b2b_frames_div3", nfd1, 1);
    wait_idle(100);

    // Reset during the third data bit, then a clean 0x0F frame.
    data_in = 8'h3C; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    repeat (6) tick();
    check_bit("mid_busy", 0, busy_o[0], 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_bit("mid_rst_seq", 0, seq_o[0], 1'b1);
    check_bit("mid_rst_busy", 0, busy_o[0], 1'b0);
    check_bit("mid_rst_fd", 0, fd_o[0], 1'b0);
    data_in = 8'h0F; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    for (int i = 0; i < 14; i++) begin
      g_seq = {g_seq[12:0], seq_o[0]};
      tick();
    end
    check_val("post_rst_0f_seq", int'(g_seq), int'(14'b00010000111111));
    wait_idle(100);

    // Loopback: 0001 detector over the DIV=1 line, three 0xFF frames.
    hist = 4'b1111; nmatch = 0;
    data_in = 8'hFF; data_valid = 1'b1;
    for (int i = 0; i < 42; i++) begin
      tick();
      if (stb_o[0] || !busy_o[0]) begin
        hist = {hist[2:0], seq_o[0]};
        if (hist == 4'b0001) begin
          nmatch++;
          check_val("loop_match_pos", m_t[0], 3);
        end
      end
    end
    data_valid = 1'b0;
    check_val("loop_matches", nmatch, 3);
    wait_idle(100);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 49) == 0);
      data_valid = ($urandom_range(0, 2) != 0);
      data_in    = 8'($urandom);
      tick();
    end
    reset = 1'b0;
    data_valid = 1'b0;
    wait_idle(100);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
